// File: rtl/rs15_9_encoder.sv
// Sequential systematic RS(15,9) encoder over GF(16), x^4+x+1.
// One message symbol per clock through a 6-stage parity LFSR; codeword lands 9 cycles after accept.
module rs15_9_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [35:0] messageIn,
  input  logic        startEncode,
  output logic        encoderBusy,
  output logic [59:0] codeWordOut,
  output logic        codeValid
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic [35:0] sym_shift;
  logic [35:0] sym_rot;
  logic [3:0]  sym_count;
  logic [3:0]  par [6];
  logic [3:0]  par_next [6];
  logic [3:0]  fb;

  function automatic logic [3:0] xt(input logic [3:0] a);
    return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
  endfunction

  // Fixed-coefficient multipliers for the generator taps g5..g0 = 7,9,3,C,A,C.
  function automatic logic [3:0] mul_7(input logic [3:0] a);
    return a ^ xt(a) ^ xt(xt(a));
  endfunction

  function automatic logic [3:0] mul_9(input logic [3:0] a);
    return a ^ xt(xt(xt(a)));
  endfunction

  function automatic logic [3:0] mul_3(input logic [3:0] a);
    return a ^ xt(a);
  endfunction

  function automatic logic [3:0] mul_c(input logic [3:0] a);
    return xt(xt(a)) ^ xt(xt(xt(a)));
  endfunction

  function automatic logic [3:0] mul_a(input logic [3:0] a);
    return xt(a) ^ xt(xt(xt(a)));
  endfunction

  // Rotating the message register means after nine shifts it holds the original message again.
  always_comb begin
    sym_rot     = {sym_shift[31:0], sym_shift[35:32]};
    fb          = sym_shift[35:32] ^ par[5];
    par_next[5] = par[4] ^ mul_7(fb);
    par_next[4] = par[3] ^ mul_9(fb);
    par_next[3] = par[2] ^ mul_3(fb);
    par_next[2] = par[1] ^ mul_c(fb);
    par_next[1] = par[0] ^ mul_a(fb);
    par_next[0] = mul_c(fb);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sym_shift   <= '0;
      sym_count   <= '0;
      encoderBusy <= 1'b0;
      codeValid   <= 1'b0;
      codeWordOut <= '0;
      for (int i = 0; i < 6; i++) par[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          codeValid <= 1'b0;
          if (startEncode) begin
            sym_shift   <= messageIn;
            sym_count   <= '0;
            encoderBusy <= 1'b1;
            state       <= SHIFT;
            for (int i = 0; i < 6; i++) par[i] <= '0;
          end
        end
        SHIFT: begin
          sym_shift <= sym_rot;
          sym_count <= sym_count + 4'd1;
          for (int i = 0; i < 6; i++) par[i] <= par_next[i];
          if (sym_count == 4'd8) begin
            codeWordOut <= {sym_rot, par_next[5], par_next[4], par_next[3],
                            par_next[2], par_next[1], par_next[0]};
            codeValid   <= 1'b1;
            encoderBusy <= 1'b0;
            sym_count   <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
